// File: rtl/cp0_pkg.sv
// rtl/cp0_pkg.sv - shared constants for the coprocessor-0 exception/interrupt controller
//
// Purpose: register numbers, field bit positions and exception codes used by
//          cp0 and by the pipeline stages that feed it ExcCode.
// Ports:   none (package).
package cp0_pkg;

   // Coprocessor-0 register numbers
   localparam logic [4:0] REG_SR    = 5'd12;
   localparam logic [4:0] REG_CAUSE = 5'd13;
   localparam logic [4:0] REG_EPC   = 5'd14;
   localparam logic [4:0] REG_PRID  = 5'd15;

   // SR field positions
   localparam int SR_IM_HI = 15;
   localparam int SR_IM_LO = 10;
   localparam int SR_EXL   = 1;
   localparam int SR_IE    = 0;

   // Cause field positions
   localparam int CAUSE_BD     = 31;
   localparam int CAUSE_IP_HI  = 15;
   localparam int CAUSE_IP_LO  = 10;
   localparam int CAUSE_EXC_HI = 6;
   localparam int CAUSE_EXC_LO = 2;

   // Exception codes carried down the pipeline; the execute-stage ALU
   // overflow flag is mapped to EXC_OV.
   localparam logic [4:0] EXC_INT  = 5'd0;
   localparam logic [4:0] EXC_ADEL = 5'd4;
   localparam logic [4:0] EXC_ADES = 5'd5;
   localparam logic [4:0] EXC_RI   = 5'd10;
   localparam logic [4:0] EXC_OV   = 5'd12;

   // EPC is always word aligned
   function automatic logic [31:0] epc_align(input logic [31:0] v);
      return v & ~32'h0000_0003;
   endfunction

endpackage

// File: rtl/cp0.sv
// rtl/cp0.sv - coprocessor-0 exception and interrupt controller
//
// Purpose: holds SR, Cause, EPC and PRId; raises IntReq when an enabled
//          hardware interrupt or a memory-stage exception must redirect the
//          pipeline; serves mfc0 reads and mtc0 writes; eret clears EXL.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   A1           mfc0 read register number
//   A2, DIn, WE  mtc0 register number, data, enable
//   PC, BD       memory-stage PC and branch-delay-slot flag
//   ExcCode      memory-stage exception code (0 = none)
//   HWInt        level-sensitive external interrupt lines
//   EXLClr       eret in the memory stage
//   IntReq       take exception/interrupt this cycle (combinational)
//   EPC          registered EPC value
//   DOut         mfc0 read data (combinational, no write bypass)
module cp0
   import cp0_pkg::*;
#(
   parameter logic [31:0] PRID = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [4:0]  A1,
   input  logic [4:0]  A2,
   input  logic [31:0] DIn,
   input  logic        WE,
   input  logic [31:0] PC,
   input  logic        BD,
   input  logic [4:0]  ExcCode,
   input  logic [5:0]  HWInt,
   input  logic        EXLClr,
   output logic        IntReq,
   output logic [31:0] EPC,
   output logic [31:0] DOut
);

   // SR fields
   logic [5:0]  im;
   logic        exl;
   logic        ie;
   // Cause fields
   logic        bd_q;
   logic [5:0]  ip;
   logic [4:0]  exc_q;
   // EPC, kept word aligned on every write
   logic [31:0] epc_q;

   logic        int_req;
   logic        exc_req;
   logic [31:0] victim_pc;
   logic [31:0] sr_word;
   logic [31:0] cause_word;

   assign int_req = (|(HWInt & im)) & ie & ~exl;
   assign exc_req = (ExcCode != 5'd0) & ~exl;
   assign IntReq  = int_req | exc_req;

   // A delay-slot instruction restarts at its branch; wraps below address 0
   assign victim_pc = BD ? (PC - 32'd4) : PC;

   assign sr_word    = {16'b0, im, 8'b0, exl, ie};
   assign cause_word = {bd_q, 15'b0, ip, 3'b0, exc_q, 2'b0};
   assign EPC        = epc_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         im    <= '0;
         exl   <= 1'b0;
         ie    <= 1'b0;
         bd_q  <= 1'b0;
         ip    <= '0;
         exc_q <= '0;
         epc_q <= '0;
      end else begin
         ip <= HWInt;
         if (IntReq) begin
            // Taking the trap blocks mtc0 and eret on the same edge
            exl   <= 1'b1;
            exc_q <= int_req ? EXC_INT : ExcCode;
            bd_q  <= BD;
            epc_q <= epc_align(victim_pc);
         end else begin
            if (WE && (A2 == REG_SR)) begin
               im  <= DIn[SR_IM_HI:SR_IM_LO];
               exl <= DIn[SR_EXL];
               ie  <= DIn[SR_IE];
            end
            if (WE && (A2 == REG_EPC)) begin
               epc_q <= epc_align(DIn);
            end
            // Placed after the SR write so eret wins for EXL while the
            // written IM/IE survive
            if (EXLClr) begin
               exl <= 1'b0;
            end
         end
      end
   end

   always_comb begin
      DOut = '0;
      case (A1)
         REG_SR:    DOut = sr_word;
         REG_CAUSE: DOut = cause_word;
         REG_EPC:   DOut = epc_q;
         REG_PRID:  DOut = PRID;
         default:   DOut = '0;
      endcase
   end

endmodule

// File: tb/tb_cp0.sv
// tb/tb_cp0.sv - self-checking bench for cp0 with a word-level reference model
module tb_cp0;

   localparam logic [31:0] PRID_V = 32'h0001_9300;

   logic        clk;
   logic        rst_n;
   logic [4:0]  A1;
   logic [4:0]  A2;
   logic [31:0] DIn;
   logic        WE;
   logic [31:0] PC;
   logic        BD;
   logic [4:0]  ExcCode;
   logic [5:0]  HWInt;
   logic        EXLClr;
   logic        IntReq;
   logic [31:0] EPC;
   logic [31:0] DOut;

   int n_checks = 0;
   int n_fail   = 0;

   cp0 #(.PRID(PRID_V)) dut (
      .clk(clk), .rst_n(rst_n), .A1(A1), .A2(A2), .DIn(DIn), .WE(WE),
      .PC(PC), .BD(BD), .ExcCode(ExcCode), .HWInt(HWInt), .EXLClr(EXLClr),
      .IntReq(IntReq), .EPC(EPC), .DOut(DOut)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: whole register words
   logic [31:0] m_sr, m_cause, m_epc;
   logic [31:0] n_sr, n_cause, n_epc;
   logic        t_int, t_req;

   function automatic bit m_int();
      return ((HWInt & m_sr[15:10]) != 6'd0) && m_sr[0] && !m_sr[1];
   endfunction

   function automatic bit m_ireq();
      return m_int() || ((ExcCode != 5'd0) && !m_sr[1]);
   endfunction

   function automatic logic [31:0] m_dout(input logic [4:0] a);
      case (a)
         5'd12:   return m_sr;
         5'd13:   return m_cause;
         5'd14:   return m_epc;
         5'd15:   return PRID_V;
         default: return 32'h0;
      endcase
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_sr = 32'h0; m_cause = 32'h0; m_epc = 32'h0;
      end else begin
         t_int   = m_int();
         t_req   = m_ireq();
         n_sr    = m_sr;
         n_epc   = m_epc;
         n_cause = (m_cause & ~32'h0000_FC00) | (32'(HWInt) << 10);
         if (t_req) begin
            n_sr    = m_sr | 32'h2;
            n_cause = (n_cause & 32'h0000_FC00)
                    | (t_int ? 32'h0 : (32'(ExcCode) << 2))
                    | (BD ? 32'h8000_0000 : 32'h0);
            n_epc   = (BD ? PC - 32'd4 : PC) & 32'hFFFF_FFFC;
         end else begin
            if (WE && A2 == 5'd12) n_sr = DIn & 32'h0000_FC03;
            if (WE && A2 == 5'd14) n_epc = DIn & 32'hFFFF_FFFC;
            if (EXLClr) n_sr = n_sr & ~32'h2;
         end
         m_sr = n_sr; m_cause = n_cause; m_epc = n_epc;
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Continuous compare against the model, away from the active edge
   always @(negedge clk) begin
      check("cmp_intreq", {31'b0, IntReq}, {31'b0, m_ireq()});
      check("cmp_epc", EPC, m_epc);
      check("cmp_dout", DOut, m_dout(A1));
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic rd(input logic [4:0] a, input logic [31:0] exp, input string name);
      A1 = a;
      #1;
      check(name, DOut, exp);
   endtask

   task automatic chk_irq(input logic exp, input string name);
      #1;
      check(name, {31'b0, IntReq}, {31'b0, exp});
   endtask

   initial begin
      rst_n = 1'b0; A1 = 5'd0; A2 = 5'd0; DIn = 32'h0; WE = 1'b0;
      PC = 32'h0; BD = 1'b0; ExcCode = 5'd0; HWInt = 6'd0; EXLClr = 1'b0;

      // Reset state
      #12;
      rd(5'd12, 32'h0, "rst_sr");
      rd(5'd13, 32'h0, "rst_cause");
      rd(5'd14, 32'h0, "rst_epc_rd");
      rd(5'd15, PRID_V, "rst_prid");
      rd(5'd3, 32'h0, "rst_unimpl");
      chk_irq(1'b0, "rst_irq0");
      ExcCode = 5'd5;
      chk_irq(1'b1, "rst_irq_exc");
      ExcCode = 5'd0;
      @(posedge clk); #3 rst_n = 1'b1;

      // Interrupt
      step(); WE = 1'b1; A2 = 5'd12; DIn = 32'h0000_0401;
      rd(5'd12, 32'h0, "no_bypass");
      step(); WE = 1'b0; HWInt = 6'b000001; PC = 32'h0000_3010; BD = 1'b0;
      chk_irq(1'b1, "int_irq");
      rd(5'd12, 32'h0000_0401, "int_sr_written");
      step(); HWInt = 6'd0;
      rd(5'd13, 32'h0000_0400, "int_cause");
      rd(5'd12, 32'h0000_0403, "int_sr");
      check("int_epc", EPC, 32'h0000_3010);
      chk_irq(1'b0, "int_irq_drop");

      // eret together with mtc0 SR
      WE = 1'b1; A2 = 5'd12; DIn = 32'h0000_0403; EXLClr = 1'b1;
      step(); WE = 1'b0; EXLClr = 1'b0;
      rd(5'd12, 32'h0000_0401, "eret_mtc0_sr");
      WE = 1'b1; A2 = 5'd12; DIn = 32'h0;

      // Overflow in a delay slot, then held (masked)
      step(); WE = 1'b0; ExcCode = 5'd12; PC = 32'h0000_3020; BD = 1'b1;
      chk_irq(1'b1, "ov_irq");
      step(); PC = 32'h0000_9000; BD = 1'b0;
      chk_irq(1'b0, "ov_masked");
      rd(5'd13, 32'h8000_0030, "ov_cause");
      check("ov_epc", EPC, 32'h0000_301C);
      step(); ExcCode = 5'd0;
      check("ov_epc_kept", EPC, 32'h0000_301C);
      rd(5'd12, 32'h0000_0002, "ov_sr");
      WE = 1'b1; A2 = 5'd12; DIn = 32'h0000_0403; EXLClr = 1'b1;

      // Interrupt beats exception; mtc0 EPC dropped
      step(); EXLClr = 1'b0;
      rd(5'd12, 32'h0000_0401, "prio_sr");
      HWInt = 6'b000001; ExcCode = 5'd12; A2 = 5'd14; DIn = 32'h0000_1234;
      PC = 32'h0000_4000; BD = 1'b0;
      chk_irq(1'b1, "prio_irq");
      step(); WE = 1'b0; HWInt = 6'd0; ExcCode = 5'd0;
      rd(5'd13, 32'h0000_0400, "prio_cause");
      check("prio_epc", EPC, 32'h0000_4000);
      EXLClr = 1'b1;

      // PC-4 wrap below zero
      step(); EXLClr = 1'b0; ExcCode = 5'd10; BD = 1'b1; PC = 32'h0;
      chk_irq(1'b1, "wrap_irq");
      step(); ExcCode = 5'd0; BD = 1'b0;
      rd(5'd13, 32'h8000_0028, "wrap_cause");
      check("wrap_epc", EPC, 32'hFFFF_FFFC);
      EXLClr = 1'b1;

      // Reset during the IntReq cycle
      step(); EXLClr = 1'b0; ExcCode = 5'd4; PC = 32'h0000_5000;
      chk_irq(1'b1, "rmx_irq");
      rst_n = 1'b0;
      chk_irq(1'b1, "rmx_irq_exc_held");
      ExcCode = 5'd0;
      chk_irq(1'b0, "rmx_irq_dropped");
      step();
      rd(5'd12, 32'h0, "rmx_sr");
      rd(5'd13, 32'h0, "rmx_cause");
      check("rmx_epc", EPC, 32'h0);
      rst_n = 1'b1;

      // Randomized phase against the model
      for (int i = 0; i < 3000; i++) begin
         step();
         A1      = 5'($urandom_range(0, 31));
         if ($urandom_range(0, 3) != 0) A1 = 5'($urandom_range(12, 15));
         WE      = ($urandom_range(0, 3) == 0);
         case ($urandom_range(0, 4))
            0: A2 = 5'd12;
            1: A2 = 5'd13;
            2: A2 = 5'd14;
            3: A2 = 5'd15;
            default: A2 = 5'($urandom_range(0, 31));
         endcase
         DIn     = $urandom;
         PC      = $urandom;
         if ($urandom_range(0, 15) == 0) PC = 32'($urandom_range(0, 3));
         BD      = $urandom_range(0, 1) == 1;
         EXLClr  = ($urandom_range(0, 5) == 0);
         HWInt   = ($urandom_range(0, 3) == 0) ? 6'($urandom) : 6'd0;
         case ($urandom_range(0, 11))
            0: ExcCode = 5'd4;
            1: ExcCode = 5'd5;
            2: ExcCode = 5'd10;
            3: ExcCode = 5'd12;
            4: ExcCode = 5'($urandom);
            default: ExcCode = 5'd0;
         endcase
         if (i % 700 == 699) begin
            #2 rst_n = 1'b0;
            #1 rst_n = 1'b1;
         end
      end

      step();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
